// File: rtl/branch_predict_ctrl_pkg.sv
// branch_predict_ctrl_pkg: shared widths, opcode, counter encodings and FSM states
package branch_predict_ctrl_pkg;
  localparam int AW = 5;
  localparam logic [6:0] BRANCH_OP = 7'b1100011;
  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;
  typedef enum logic {RUN, RECOVER} state_t;
endpackage

// File: rtl/bht_counter_table.sv
// bht_counter_table: 2-bit saturating counter array, combinational read, saturating write
module bht_counter_table
  import branch_predict_ctrl_pkg::*;
#(
  parameter int ENTRIES = 8,
  parameter logic [1:0] CNT_INIT = WNT,
  parameter int IW = $clog2(ENTRIES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [IW-1:0] rd_idx,
  output logic [1:0]    rd_cnt,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic          wr_taken
);
  logic [ENTRIES-1:0][1:0] cnt_q, cnt_d;
  logic [1:0] cur;
  always_comb begin
    rd_cnt = cnt_q[rd_idx];
    cur = cnt_q[wr_idx];
    cnt_d = cnt_q;
    if (wr_en) cnt_d[wr_idx] = wr_taken ? (cur == ST ? ST : cur + 2'd1) : (cur == SNT ? SNT : cur - 2'd1);
  end
  always_ff @(posedge clk) cnt_q <= reset ? {ENTRIES{CNT_INIT}} : cnt_d;
endmodule

// File: rtl/branch_predict_ctrl.sv
// branch_predict_ctrl: bimodal branch prediction with one-cycle mispredict recovery
module branch_predict_ctrl
  import branch_predict_ctrl_pkg::*;
#(
  parameter int AW = branch_predict_ctrl_pkg::AW,
  parameter int BHT_ENTRIES = 8,
  parameter logic [1:0] CNT_INIT = WNT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          hazard_stall,
  input  logic          if_valid,
  input  logic          if_is_branch,
  input  logic [AW-1:0] if_pc,
  input  logic [AW-1:0] if_target,
  input  logic          ex_valid,
  input  logic          ex_is_branch,
  input  logic          ex_taken,
  input  logic          ex_pred_taken,
  input  logic [AW-1:0] ex_pc,
  input  logic [AW-1:0] ex_target,
  output logic          pred_taken,
  output logic          redirect,
  output logic [AW-1:0] redirect_pc,
  output logic          stall,
  output logic          clr,
  output logic [7:0]    mispredict_cnt
);
  localparam int IW = $clog2(BHT_ENTRIES);
  state_t state_q, state_d;
  logic [AW-1:0] correct_pc_q, correct_pc_d;
  logic [7:0] mispredict_cnt_q, mispredict_cnt_d;
  logic [1:0] rd_cnt;
  logic res, mis, unused_pc;
  assign unused_pc = ^if_pc;
  bht_counter_table #(.ENTRIES(BHT_ENTRIES), .CNT_INIT(CNT_INIT), .IW(IW)) u_bht (
    .clk, .reset, .rd_idx(if_pc[IW-1:0]), .rd_cnt,
    .wr_en(res), .wr_idx(ex_pc[IW-1:0]), .wr_taken(ex_taken)
  );
  always_comb begin
    res = ex_valid & ex_is_branch & ~hazard_stall;
    mis = res & (ex_taken ^ ex_pred_taken);
    pred_taken = (state_q == RUN) & if_valid & if_is_branch & rd_cnt[1];
    clr = state_q == RECOVER;
    redirect = clr | pred_taken;
    redirect_pc = clr ? correct_pc_q : if_target;
    stall = hazard_stall;
    state_d = mis ? RECOVER : RUN;
    correct_pc_d = mis ? (ex_taken ? ex_target : ex_pc + AW'(1)) : correct_pc_q;
    mispredict_cnt_d = (mis && mispredict_cnt_q != 8'hff) ? mispredict_cnt_q + 8'd1 : mispredict_cnt_q;
  end
  assign mispredict_cnt = mispredict_cnt_q;
  always_ff @(posedge clk) begin
    state_q <= reset ? RUN : state_d;
    correct_pc_q <= reset ? '0 : correct_pc_d;
    mispredict_cnt_q <= reset ? '0 : mispredict_cnt_d;
  end
endmodule

// File: doc/branch_predict_ctrl.md
BRANCH_PREDICT_CTRL -- requirements
Module: branch_predict_ctrl

Interface
REQ-001 Parameter AW, default 5: instruction address width.
REQ-002 Parameter BHT_ENTRIES, default 8, power of two: branch history table size, indexed by pc[log2(BHT_ENTRIES)-1:0].
REQ-003 Parameter CNT_INIT, default 2'b01: reset value of every 2-bit counter (weakly not-taken).
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port hazard_stall, input, 1: downstream stall request.
REQ-007 Ports if_valid / if_is_branch, input, 1 each: fetch slot valid / fetched word is a conditional branch (opcode 1100011).
REQ-008 Ports if_pc / if_target, input, AW each: fetch address / decoded branch target.
REQ-009 Ports ex_valid / ex_is_branch / ex_taken / ex_pred_taken, input, 1 each: resolved instruction valid / is branch / actual outcome / prediction carried down the pipe.
REQ-010 Ports ex_pc / ex_target, input, AW each: resolved branch address / taken target.
REQ-011 Port pred_taken, output, 1: prediction for the current fetch slot.
REQ-012 Ports redirect (output, 1) / redirect_pc (output, AW): PC select and jump address to the program counter.
REQ-013 Ports stall (output, 1) / clr (output, 1): freeze PC and fetch register / flush fetch register.
REQ-014 Port mispredict_cnt, output, 8: saturating mispredict count.

Function
REQ-015 FSM states RUN and RECOVER; reset state RUN.
REQ-016 In RUN: pred_taken = if_valid & if_is_branch & counter[idx(if_pc)][1], combinational, same cycle.
REQ-017 In RUN with pred_taken=1: redirect=1, redirect_pc=if_target, same cycle; otherwise redirect=0.
REQ-018 Resolve qualifier: res = ex_valid & ex_is_branch & ~hazard_stall; ex inputs are ignored when res=0.
REQ-019 Counter update on res: ex_taken=1 increments, saturating at 3; ex_taken=0 decrements, saturating at 0; written at the clock edge.
REQ-020 Mispredict = res & (ex_taken != ex_pred_taken); registers correct_pc = ex_taken ? ex_target : ex_pc+1, modulo 2^AW (31 wraps to 0).
REQ-021 Transition RUN->RECOVER on mispredict; RECOVER->RUN unconditionally after one cycle.
REQ-022 In RECOVER: redirect=1, redirect_pc=correct_pc, clr=1, pred_taken=0; the mispredict penalty is exactly 1 cycle after detection.
REQ-023 stall = hazard_stall, and is never asserted by this block itself.
REQ-024 A mispredict detected while in RECOVER is impossible by pipeline construction; if it occurs, the new correct_pc overwrites the old one and the FSM stays in RECOVER one more cycle.
REQ-025 Same-index read and update in one cycle: the prediction uses the pre-update counter (read-before-write).
REQ-026 mispredict_cnt increments on each mispredict and holds at 255.

Reset
REQ-027 Reset gives: state=RUN, all counters=CNT_INIT, correct_pc=0, mispredict_cnt=0.
REQ-028 Registered outputs after reset: redirect=0, clr=0, pred_taken=0 until the inputs drive them.
REQ-029 Reset asserted in RECOVER aborts the redirect; clr and redirect are 0 in the cycle after the reset edge.

Structure
REQ-030 A shared package holds AW, the opcode constant BRANCH_OP=7'b1100011, the counter encodings SNT=0/WNT=1/WT=2/ST=3, and the state enum.
REQ-031 One sub-module, bht_counter_table, holds the counter array, the combinational read port and the saturating write port.
REQ-032 The FSM, the correct-PC register and mispredict_cnt reside in branch_predict_ctrl.

Verification
REQ-033 After reset, branch at pc=6 with target 30, if_valid=1 -> pred_taken=0, redirect=0 (counter 01).
REQ-034 Resolve pc=6 taken twice (ex_pred_taken=0) -> counter 11, mispredict_cnt=2, each followed by one RECOVER cycle with redirect_pc=30 and clr=1.
REQ-035 Then fetch pc=6 -> pred_taken=1, redirect=1, redirect_pc=30 in the same cycle.
REQ-036 Resolve pc=31 not-taken with ex_pred_taken=1 -> next cycle redirect_pc=0 (wrap), clr=1.
REQ-037 Resolve with hazard_stall=1 -> no counter change, no RECOVER, stall=1.
REQ-038 260 forced mispredicts -> mispredict_cnt=255; reset during RECOVER -> next cycle clr=0, counters=01.
